// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default pixel width, pooling-mode encoding and
// width helpers used by the pooling, convolution and fully-connected blocks.
package cnn_pkg;

    localparam int unsigned CNN_DATA_W = 32;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int unsigned pool_sum_w(input int unsigned data_w, input int unsigned pool);
        return data_w + 2 * $clog2(pool);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_combine.sv
// Combines a row-buffer partial result with one pixel (signed max or add) and
// produces the final pooled pixel (average shift, truncation, optional ReLU).
module pool_combine
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = CNN_DATA_W,
    parameter int unsigned POOL   = 2,
    localparam int unsigned SUM_W = pool_sum_w(DATA_W, POOL)
) (
    input  logic [SUM_W-1:0]  acc,
    input  logic [DATA_W-1:0] pix,
    input  logic              first,
    input  logic              pool_avg,
    input  logic              relu_en,
    output logic [SUM_W-1:0]  acc_next,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned SHIFT = 2 * $clog2(POOL);

    pool_mode_e                mode;
    logic signed [SUM_W-1:0]   acc_s;
    logic signed [SUM_W-1:0]   pix_ext;
    logic signed [SUM_W-1:0]   comb;
    logic signed [DATA_W-1:0]  pooled;

    always_comb begin
        mode    = pool_mode_e'(pool_avg);
        acc_s   = acc;
        pix_ext = {{(SUM_W-DATA_W){pix[DATA_W-1]}}, pix};
        if (first) begin
            comb = pix_ext;
        end else if (mode == POOL_AVG) begin
            comb = acc_s + pix_ext;
        end else begin
            comb = (acc_s > pix_ext) ? acc_s : pix_ext;
        end
        acc_next = comb;
        // Arithmetic shift floors toward -inf before truncation to pixel width.
        pooled   = DATA_W'((mode == POOL_AVG) ? (comb >>> SHIFT) : comb);
        result   = (relu_en && pooled[DATA_W-1]) ? '0 : pooled;
    end

endmodule

// File: rtl/relu_pool_stream.sv
// Streaming max/average pooling with optional ReLU over raster-order frames,
// with ready/valid handshakes on both sides and a sticky frame-sync error flag.
module relu_pool_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = CNN_DATA_W,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned POOL   = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              relu_en,
    input  logic              pool_avg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              err_sof
);

    localparam int unsigned LP    = $clog2(POOL);
    localparam int unsigned SUM_W = pool_sum_w(DATA_W, POOL);
    localparam int unsigned OW    = IMG_W / POOL;
    localparam int unsigned OH    = IMG_H / POOL;
    localparam int unsigned CW    = $clog2(IMG_W + 1);
    localparam int unsigned RW    = $clog2(IMG_H + 1);
    localparam int unsigned IW    = idx_w(OW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_SOF
    } state_e;

    state_e            state, state_nxt;
    logic [CW-1:0]     col, eff_col;
    logic [RW-1:0]     row, eff_row;
    logic              relu_q, avg_q, relu_cur, avg_cur;
    logic              accept, take, in_win, first_px, last_px, frame_end;
    logic [IW-1:0]     idx;
    logic [SUM_W-1:0]  row_buf [1<<IW];
    logic [SUM_W-1:0]  acc_next;
    logic [DATA_W-1:0] result;

    always_comb begin
        in_ready  = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        take      = accept && (in_sof || state == ST_RUN);
        // A frame start always maps to position (0,0) and uses the live mode inputs.
        eff_col   = in_sof ? '0 : col;
        eff_row   = in_sof ? '0 : row;
        relu_cur  = in_sof ? relu_en : relu_q;
        avg_cur   = in_sof ? pool_avg : avg_q;
        in_win    = (eff_col < CW'(OW * POOL)) && (eff_row < RW'(OH * POOL));
        idx       = IW'(eff_col >> LP);
        first_px  = (eff_col[LP-1:0] == '0) && (eff_row[LP-1:0] == '0);
        last_px   = (&eff_col[LP-1:0]) && (&eff_row[LP-1:0]);
        frame_end = (eff_col == CW'(IMG_W - 1)) && (eff_row == RW'(IMG_H - 1));
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = frame_end ? ST_WAIT_SOF : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    pool_combine #(
        .DATA_W (DATA_W),
        .POOL   (POOL)
    ) u_combine (
        .acc      (row_buf[idx]),
        .pix      (in_data),
        .first    (first_px),
        .pool_avg (avg_cur),
        .relu_en  (relu_cur),
        .acc_next (acc_next),
        .result   (result)
    );

    always_ff @(posedge clk) begin
        if (take && in_win) begin
            row_buf[idx] <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            col       <= '0;
            row       <= '0;
            relu_q    <= 1'b0;
            avg_q     <= 1'b0;
            err_sof   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (accept && (in_sof ? (state == ST_RUN) : (state != ST_RUN))) begin
                err_sof <= 1'b1;
            end
            if (take) begin
                if (in_sof) begin
                    relu_q <= relu_en;
                    avg_q  <= pool_avg;
                end
                if (eff_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end
            // A load only happens on accept, so the register is free or draining.
            if (take && in_win && last_px) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_sof   <= (eff_row < RW'(POOL)) && (idx == '0);
                out_eof   <= ((eff_row >> LP) == RW'(OH - 1)) && (idx == IW'(OW - 1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_pool_stream.sv
// Directed bench for relu_pool_stream: an 8x8 and a 9x9 instance checked
// against a window-level pooling model plus hand-computed literal values.
module tb_relu_pool_stream;

    logic        clk = 1'b0;
    logic        rstb, relu_en, pool_avg, in_valid, in_sof, out_ready, sel;
    logic [31:0] in_data;
    logic        rdy_a, rdy_b, ov_a, ov_b, osof_a, osof_b, oeof_a, oeof_b, err_a, err_b;
    logic [31:0] od_a, od_b;
    logic        in_ready, ov, osof, oeof;
    logic [31:0] od;

    always #5 clk = ~clk;

    assign in_ready = sel ? rdy_b : rdy_a;
    assign ov       = sel ? ov_b : ov_a;
    assign od       = sel ? od_b : od_a;
    assign osof     = sel ? osof_b : osof_a;
    assign oeof     = sel ? oeof_b : oeof_a;

    relu_pool_stream #(.DATA_W(32), .IMG_W(8), .IMG_H(8), .POOL(2)) dut_a (
        .clk(clk), .rstb(rstb), .relu_en(relu_en), .pool_avg(pool_avg),
        .in_valid(in_valid && !sel), .in_ready(rdy_a), .in_sof(in_sof), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .out_sof(osof_a), .out_eof(oeof_a), .err_sof(err_a)
    );

    relu_pool_stream #(.DATA_W(32), .IMG_W(9), .IMG_H(9), .POOL(2)) dut_b (
        .clk(clk), .rstb(rstb), .relu_en(relu_en), .pool_avg(pool_avg),
        .in_valid(in_valid && sel), .in_ready(rdy_b), .in_sof(in_sof), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .out_sof(osof_b), .out_eof(oeof_b), .err_sof(err_b)
    );

    typedef struct {
        int data;
        bit sof;
        bit eof;
    } exp_t;

    exp_t        exp_q[$];
    int          obs[$];
    int          pix[0:127];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stalls;
    bit          hold_pend = 1'b0;
    logic [33:0] hold_val;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int obs_at(input int i);
        return (obs.size() > i) ? obs[i] : -999;
    endfunction

    // Expected outputs of every window whose pixels all lie within the first n.
    task automatic model(input int n, input int w, input int h, input bit avg, input bit relu);
        for (int oy = 0; oy < h / 2; oy++) begin
            for (int ox = 0; ox < w / 2; ox++) begin
                longint s;
                int     m, r, v;
                exp_t   e;
                if ((oy * 2 + 1) * w + ox * 2 + 1 < n) begin
                    s = 0;
                    m = pix[oy * 2 * w + ox * 2];
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            v = pix[(oy * 2 + dy) * w + ox * 2 + dx];
                            s += v;
                            if (v > m) m = v;
                        end
                    end
                    r = avg ? int'((s - (((s % 4) + 4) % 4)) / 4) : m;
                    if (relu && r < 0) r = 0;
                    e.data = r;
                    e.sof  = (oy == 0) && (ox == 0);
                    e.eof  = (oy == h / 2 - 1) && (ox == w / 2 - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic send(input int n, input bit rnd, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int guard;
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
                in_valid = rnd ? 1'($urandom % 2) : 1'b1;
                in_data  = pix[i];
                in_sof   = (i == 0) && sof_first;
                if (rnd) out_ready = 1'($urandom % 2);
                @(negedge clk);
                hs = in_valid && in_ready;
                if (in_valid && !in_ready) stalls++;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: pixel %0d not accepted, expected accept within 100 cycles", i);
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int g;
        out_ready = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) pix[i] = i;
    endtask

    always @(negedge clk) begin
        if (!rstb) begin
            hold_pend = 1'b0;
        end else begin
            if (sel ? ov_a : ov_b) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_instance_valid: got 1 expected 0");
            end
            if (hold_pend) begin
                n_cmp++;
                if (!ov || {od, osof, oeof} !== hold_val) begin
                    n_bad++;
                    $display("FAIL hold_stable: got valid=%0b data=%0d expected held data=%0d",
                             ov, $signed(od), $signed(hold_val[33:2]));
                end
            end
            hold_pend = 1'b0;
            if (ov) begin
                if (out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_output: got data=%0d expected no output", $signed(od));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (od !== e.data || osof !== e.sof || oeof !== e.eof) begin
                            n_bad++;
                            $display("FAIL output: got data=%0d sof=%0b eof=%0b expected data=%0d sof=%0b eof=%0b",
                                     $signed(od), osof, oeof, e.data, e.sof, e.eof);
                        end
                    end
                    obs.push_back(int'(od));
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = {od, osof, oeof};
                end
            end
        end
    end

    initial begin
        rstb      = 1'b0;
        relu_en   = 1'b0;
        pool_avg  = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ov_a, 0);
        check("rst_out_data", od_a, 0);
        check("rst_out_sof_eof", {osof_a, oeof_a}, 0);
        check("rst_err_sof", err_a, 0);
        check("rst_in_ready", rdy_a, 1);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Ramp, max pooling, full throughput
        fill_ramp(64);
        obs.delete();
        model(64, 8, 8, 0, 0);
        stalls = 0;
        send(64, 0, 1);
        drain();
        check("max_first", obs_at(0), 9);
        check("max_second", obs_at(1), 11);
        check("max_row1", obs_at(4), 25);
        check("max_last", obs_at(15), 63);
        check("max_count", obs.size(), 16);
        check("max_stalls", stalls, 0);

        // Ramp, average pooling
        pool_avg = 1'b1;
        obs.delete();
        model(64, 8, 8, 1, 0);
        send(64, 0, 1);
        drain();
        check("avg_first", obs_at(0), 4);
        check("avg_row1", obs_at(4), 20);
        check("avg_last", obs_at(15), 58);

        // Constant -5 with and without ReLU
        for (int i = 0; i < 64; i++) pix[i] = -5;
        relu_en = 1'b1;
        obs.delete();
        model(64, 8, 8, 1, 1);
        send(64, 0, 1);
        drain();
        check("neg_relu", obs_at(7), 0);
        check("neg_relu_count", obs.size(), 16);
        relu_en = 1'b0;
        obs.delete();
        model(64, 8, 8, 1, 0);
        send(64, 0, 1);
        drain();
        check("neg_norelu", obs_at(9), -5);

        // Random valid and backpressure, max pooling
        pool_avg = 1'b0;
        fill_ramp(64);
        obs.delete();
        model(64, 8, 8, 0, 0);
        send(64, 1, 1);
        drain();
        check("bp_third", obs_at(2), 13);
        check("bp_last", obs_at(15), 63);
        check("bp_count", obs.size(), 16);

        // 9x9 frame: last column and row discarded
        sel = 1'b1;
        fill_ramp(81);
        obs.delete();
        model(81, 9, 9, 0, 0);
        send(81, 0, 1);
        drain();
        check("odd_first", obs_at(0), 10);
        check("odd_last", obs_at(15), 70);
        check("odd_count", obs.size(), 16);
        sel = 1'b0;

        // Frame restart after 20 pixels
        check("err_clean", err_a, 0);
        fill_ramp(64);
        obs.delete();
        model(20, 8, 8, 0, 0);
        send(20, 0, 1);
        model(64, 8, 8, 0, 0);
        send(64, 0, 1);
        drain();
        check("restart_err", err_a, 1);
        check("restart_count", obs.size(), 20);
        check("restart_partial_last", obs_at(3), 15);
        check("restart_new_first", obs_at(4), 9);

        // Reset pulse while an output is held
        rstb = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
        check("err_after_reset", err_a, 0);
        out_ready = 1'b0;
        send(10, 0, 1);
        #2;
        check("held_before_reset", ov_a, 1);
        rstb = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", ov_a, 0);
        check("async_rst_data", od_a, 0);
        @(posedge clk);
        #1;
        rstb      = 1'b1;
        out_ready = 1'b1;

        // Missing in_sof after reset: pixel dropped, then a clean frame
        pix[0] = 1000;
        obs.delete();
        send(1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("drop_err", err_a, 1);
        check("drop_no_output", obs.size(), 0);
        pool_avg = 1'b1;
        fill_ramp(64);
        model(64, 8, 8, 1, 0);
        send(64, 0, 1);
        drain();
        check("post_reset_first", obs_at(0), 4);
        check("post_reset_count", obs.size(), 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relu_pool_stream.md
RELU_POOL_STREAM -- requirements
Module: relu_pool_stream

Interface
REQ-001 Parameter DATA_W, 32, signed pixel width in bits.
REQ-002 Parameter IMG_W, 8, input frame width in pixels.
REQ-003 Parameter IMG_H, 8, input frame height in pixels.
REQ-004 Parameter POOL, 2, pooling window side and stride; power of two, 2..8.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port rstb  input  1  reset, asynchronous, active-low.
REQ-007 Port relu_en  input  1  ReLU on pooled result; sampled with first pixel of frame.
REQ-008 Port pool_avg  input  1  0 = max pooling, 1 = average pooling; sampled with first pixel of frame.
REQ-009 Port in_valid / in_ready  input / output  1 / 1  input handshake; transfer when both are high.
REQ-010 Port in_sof  input  1  first pixel of frame, raster order.
REQ-011 Port in_data  input  DATA_W  signed pixel.
REQ-012 Port out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-013 Port out_data  output  DATA_W  signed pooled pixel.
REQ-014 Port out_sof / out_eof  output  1 / 1  first / last pooled pixel of frame, valid with out_valid.
REQ-015 Port err_sof  output  1  sticky: in_sof seen mid-frame or missing at frame start.

Function
REQ-016 Output grid: OW = IMG_W/POOL, OH = IMG_H/POOL (floor); pixels in columns >= OW*POOL or rows >= OH*POOL are accepted and discarded.
REQ-017 Row buffer: OW partial results (max or sum), sum width DATA_W + 2*log2(POOL), no overflow.
REQ-018 Window's first pixel (row%POOL==0, col%POOL==0) overwrites its entry; other pixels combine (signed max or add).
REQ-019 Accepting a window's last pixel loads the output register next edge: out_valid high 1 cycle after that accept.
REQ-020 Average = full sum arithmetically shifted right by 2*log2(POOL) (floor toward -inf), then truncated to DATA_W.
REQ-021 ReLU (relu_en=1): negative results become 0, applied after pooling.
REQ-022 in_ready = !out_valid || out_ready; no pixel lost or duplicated under any backpressure.
REQ-023 out_data/out_sof/out_eof held stable while out_valid && !out_ready.
REQ-024 States IDLE (awaiting in_sof), RUN (counting row/col), and WAIT_SOF after last pixel; WAIT_SOF returns to RUN on next in_sof.
REQ-025 Pixel with in_sof=0 in IDLE/WAIT_SOF: dropped, err_sof set.
REQ-026 in_sof=1 in RUN: row/col counters restart, pixel treated as new frame's first, mode resampled, err_sof set; pending output unaffected.
REQ-027 Frame of IMG_W*IMG_H accepted pixels emits exactly OW*OH outputs, raster order.
REQ-028 Accept and emit in the same cycle sustain 1 pixel/cycle throughput.

Reset
REQ-029 rstb low: out_valid=0, out_data=0, out_sof=0, out_eof=0, err_sof=0, counters=0, state IDLE, immediately and asynchronously.
REQ-030 Reset mid-frame discards partial windows; first post-reset pixel must carry in_sof.
REQ-031 Row buffer contents need no reset.

Structure
REQ-032 Shared package cnn_pkg holds DATA_W default, pool-mode encoding, and clog2-based width helpers, shared with conv/fully-connected blocks.
REQ-033 One sub-module, pool_combine: combinational max/add of two values plus final shift and ReLU.

Verification
REQ-034 8x8 ramp 0..63, max, relu off, out_ready=1 -> outputs 9,11,13,15,25,...,63; 16 outputs, out_eof on 63.
REQ-035 Same ramp, average -> 4,6,8,10,20,...,58 (floor of (a+b+c+d)/4, e.g. (0+1+8+9)/4=4).
REQ-036 All pixels -5, relu on, average -> 16 outputs of 0; relu off -> 16 outputs of -5.
REQ-037 out_ready toggles 1/0 randomly, in_valid random -> output sequence identical to REQ-034, no stall beyond one output held.
REQ-038 IMG_W=IMG_H=9, POOL=2, ramp 0..80 -> 16 outputs, last 70; column 8 and row 8 discarded.
REQ-039 in_sof reasserted after 20 pixels, then full frame -> err_sof=1, 16 correct outputs for new frame; rstb pulse mid-frame -> out_valid=0 within the same cycle.
